// File: rtl/data_stream_out32.sv
// Output serializer: captures NWORDS result words on a start pulse and streams them
// one word per beat over a valid/ready port, with busy/last/done status and a sticky lost flag.
module data_stream_out32 #(
   parameter int WORD_W = 32,
   parameter int NWORDS = 8,
   parameter int ORDER  = 0,
   localparam int IW    = $clog2(NWORDS)
) (
   input  logic                     CLK,
   input  logic                     rst,
   input  logic                     start,
   input  logic [WORD_W*NWORDS-1:0] DI,
   input  logic                     ordy,
   output logic                     ov,
   output logic [WORD_W-1:0]        od,
   output logic [IW-1:0]            oidx,
   output logic                     olast,
   output logic                     busy,
   output logic                     done,
   output logic                     lost
);

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

   localparam logic [IW-1:0] LAST_CNT = IW'(NWORDS - 1);

   state_t                     state;
   logic [WORD_W*NWORDS-1:0]   sh;
   logic [IW-1:0]              cnt;
   logic [IW-1:0]              wordSel;
   logic                       sending;

   always_ff @(posedge CLK) begin
      if (rst) begin
         state <= IDLE;
         sh    <= '0;
         cnt   <= '0;
         lost  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sh    <= DI;
                  cnt   <= '0;
                  state <= SEND;
               end
            end
            SEND: begin
               // A start arriving mid-block is dropped; only the sticky flag records it.
               if (start) begin
                  lost <= 1'b1;
               end
               if (ordy) begin
                  if (cnt == LAST_CNT) begin
                     cnt   <= '0;
                     state <= DONE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            DONE: begin
               if (start) begin
                  sh    <= DI;
                  cnt   <= '0;
                  state <= SEND;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign sending = (state == SEND);
   assign wordSel = (ORDER != 0) ? (LAST_CNT - cnt) : cnt;

   // Data-side outputs are forced to zero outside SEND so the idle port reads all zeros.
   assign ov    = sending;
   assign busy  = sending;
   assign done  = (state == DONE);
   assign od    = sending ? sh[int'(wordSel)*WORD_W +: WORD_W] : '0;
   assign oidx  = sending ? wordSel : '0;
   assign olast = sending && (cnt == LAST_CNT);

endmodule
